// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the toy MIPS core: fetch/decode/execute/memory/writeback
// sequencing with a bounded memory-ready wait, sticky halt and a retired-instruction count.
module mips_mc_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_re,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             zext,
    output logic [3:0]       alu_op,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic [1:0]       err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_ALUWB_R, S_EXEC_I, S_ALUWB_I,
        S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ERR_OPC   = 2'b01;
    localparam logic [1:0] ERR_FUNCT = 2'b10;
    localparam logic [1:0] ERR_BUS   = 2'b11;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t             state_q, state_d;
    logic [7:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   retired_cnt_q, retired_cnt_d;
    logic               halted_q, halted_d;
    logic [1:0]         err_q, err_d;
    logic               wait_expired;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            retired_cnt_q <= '0;
            halted_q      <= 1'b0;
            err_q         <= 2'b00;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            retired_cnt_q <= retired_cnt_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
        end
    end

    // A ready arriving while the counter sits at the limit still completes the access.
    assign wait_expired = (wait_q == WAIT_LIM);

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        err_d      = err_q;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zext       = 1'b0;
        alu_op     = ALU_ADD;
        retire     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_re    = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_BUS;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                          state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                      state_d = S_MEMADR;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        err_d   = ERR_OPC;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB_R;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    default: begin
                        state_d = S_HALT;
                        err_d   = ERR_FUNCT;
                    end
                endcase
            end
            S_ALUWB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ALUWB_I;
                case (opcode)
                    OP_ANDI: begin alu_op = ALU_AND; zext = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  zext = 1'b1; end
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB_I: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_re = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_BUS;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_HALT;
                    err_d   = ERR_BUS;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_we     = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        halted_d      = halted_q | (state_d == S_HALT);
        retired_cnt_d = retired_cnt_q + CNT_W'(retire);
    end

    assign retired_cnt = retired_cnt_q;
    assign halted      = halted_q;
    assign err_code    = err_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed instructions push expected retire records,
// a negedge monitor pops and compares them whenever the controller retires.
module tb_mips_mc_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_re, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic        zext;
    logic [3:0]  alu_op;
    logic        retire;
    logic [31:0] retired_cnt;
    logic        halted;
    logic [1:0]  err_code;
    logic [18:0] ctrlVec;

    typedef struct {
        string      name;
        int         lat;
        logic       regWe;
        logic       regDst;
        logic       memToReg;
        logic       pcWe;
        logic [1:0] pcSrc;
        logic [3:0] aluOp;
        logic       zx;
        int         cntBefore;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    int   fetchStall = 0;
    int   dataStall = 0;
    int   acc = 0;
    logic lastWait = 1'b0;
    int   expRetired = 0;
    int   nTicks;

    mips_mc_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .zext(zext), .alu_op(alu_op), .retire(retire),
        .retired_cnt(retired_cnt), .halted(halted), .err_code(err_code)
    );

    assign ctrlVec = {mem_re, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, zext, alu_op, retire};

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Memory model: an access stalls for the programmed number of cycles, then is ready.
    task automatic updReady();
        logic access;
        int   stall;
        access = (mem_re === 1'b1) || (mem_we === 1'b1);
        stall  = (iord === 1'b1) ? dataStall : fetchStall;
        mem_ready = access ? (acc >= stall) : 1'b1;
        lastWait  = access && !mem_ready;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        acc = lastWait ? acc + 1 : 0;
        updReady();
        #1;
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        opcode = '0; funct = '0; zero = 1'b0;
        fetchStall = 0; dataStall = 0;
        repeat (2) tick();
        checkOutput("rst_ctrl", 32'(ctrlVec), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        checkOutput("rst_err", 32'(err_code), 32'h0);
        checkOutput("rst_cnt", retired_cnt, 32'h0);
        sys_rst_n = 1'b1;
        expRetired = 0;
        acc = 0;
        updReady();
        #1;
    endtask

    task automatic applyStimulus(input string name, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int fSt, input int dSt, input logic pushExp,
                                 input int eLat, input logic eRegWe, input logic eRegDst,
                                 input logic eMemToReg, input logic ePcWe, input logic [1:0] ePcSrc,
                                 input logic [3:0] eAluOp, input logic eZext, output int n);
        exp_t e;
        opcode = op; funct = fn; zero = z;
        fetchStall = fSt; dataStall = dSt;
        updReady();
        if (pushExp) begin
            e.name = name; e.lat = eLat; e.regWe = eRegWe; e.regDst = eRegDst;
            e.memToReg = eMemToReg; e.pcWe = ePcWe; e.pcSrc = ePcSrc;
            e.aluOp = eAluOp; e.zx = eZext; e.cntBefore = expRetired;
            expQ.push_back(e);
            expRetired++;
        end
        #1;
        n = 0;
        while (retire !== 1'b1 && halted !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: no retire/halt within 60 cycles", name);
        end
        if (retire === 1'b1) tick();
    endtask

    // Monitor: counts cycles per instruction and compares each retire against the queue.
    int         cyc = 0;
    logic [3:0] lastOp = 4'hF;
    logic       lastZext = 1'b0;
    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst_n !== 1'b1) begin
            cyc = 0; lastOp = 4'hF; lastZext = 1'b0;
        end else if (halted === 1'b0) begin
            cyc++;
            if (alu_src_a === 1'b1) begin
                lastOp = alu_op;
                lastZext = zext;
            end
            if (retire === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_retire: got retire with empty queue, expected none");
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, "_latency"}, cyc, e.lat);
                    checkOutput({e.name, "_reg_we"}, 32'(reg_we), 32'(e.regWe));
                    checkOutput({e.name, "_reg_dst"}, 32'(reg_dst), 32'(e.regDst));
                    checkOutput({e.name, "_mem_to_reg"}, 32'(mem_to_reg), 32'(e.memToReg));
                    checkOutput({e.name, "_pc_we"}, 32'(pc_we), 32'(e.pcWe));
                    checkOutput({e.name, "_pc_src"}, 32'(pc_src), 32'(e.pcSrc));
                    checkOutput({e.name, "_alu_op"}, 32'(lastOp), 32'(e.aluOp));
                    checkOutput({e.name, "_zext"}, 32'(lastZext), 32'(e.zx));
                    checkOutput({e.name, "_cnt"}, retired_cnt, e.cntBefore);
                end
                cyc = 0; lastOp = 4'hF; lastZext = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset();
        // name, op, fn, zero, fetchStall, dataStall, push, lat, reg_we, reg_dst, m2r, pc_we, pc_src, alu_op, zext
        applyStimulus("addi", 6'b001000, 6'b000010, 1'b0, 0, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        checkOutput("cnt_after_addi", retired_cnt, 32'd1);
        applyStimulus("add",  6'b000000, 6'b100000, 1'b0, 0, 0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        applyStimulus("and",  6'b000000, 6'b100100, 1'b0, 0, 0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0010, 1'b0, nTicks);
        applyStimulus("slt",  6'b000000, 6'b101010, 1'b0, 0, 0, 1'b1, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, nTicks);
        checkOutput("cnt_after_r", retired_cnt, 32'd4);
        applyStimulus("lw_stall3", 6'b100011, 6'b0, 1'b0, 0, 3, 1'b1, 8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        applyStimulus("sw",   6'b101011, 6'b0, 1'b0, 0, 0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        applyStimulus("beq_taken", 6'b000100, 6'b0, 1'b1, 0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0001, 1'b0, nTicks);
        applyStimulus("beq_not",   6'b000100, 6'b0, 1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b0001, 1'b0, nTicks);
        applyStimulus("j",    6'b000010, 6'b0, 1'b0, 0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 4'hF, 1'b0, nTicks);
        applyStimulus("andi", 6'b001100, 6'b0, 1'b0, 0, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0010, 1'b1, nTicks);
        applyStimulus("ori",  6'b001101, 6'b0, 1'b0, 0, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0011, 1'b1, nTicks);
        applyStimulus("slti", 6'b001010, 6'b0, 1'b0, 0, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0100, 1'b0, nTicks);
        applyStimulus("lw_fetch15", 6'b100011, 6'b0, 1'b0, 15, 0, 1'b1, 20, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        checkOutput("cnt_after_seq", retired_cnt, 32'd13);
        checkOutput("no_halt_at_limit", 32'(halted), 32'h0);

        applyStimulus("ill_op", 6'b111111, 6'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        checkOutput("ill_op_cycles", nTicks, 32'd2);
        checkOutput("ill_op_halted", 32'(halted), 32'h1);
        checkOutput("ill_op_err", 32'(err_code), 32'h1);
        checkOutput("ill_op_ctrl", 32'(ctrlVec), 32'h0);
        repeat (5) tick();
        checkOutput("ill_op_ctrl_later", 32'(ctrlVec), 32'h0);
        checkOutput("ill_op_halted_later", 32'(halted), 32'h1);
        checkOutput("ill_op_cnt_frozen", retired_cnt, 32'd13);

        doReset();
        applyStimulus("ill_fn", 6'b000000, 6'b000111, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        checkOutput("ill_fn_cycles", nTicks, 32'd4);
        checkOutput("ill_fn_halted", 32'(halted), 32'h1);
        checkOutput("ill_fn_err", 32'(err_code), 32'h2);

        doReset();
        opcode = 6'b001000;
        fetchStall = 1000;
        tick();
        checkOutput("fetch_wait_ctrl", 32'(ctrlVec),
                    32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'b0000, 1'b0}));
        nTicks = 0;
        while (halted !== 1'b1 && nTicks < 40) begin
            tick();
            nTicks++;
        end
        checkOutput("bus_to_cycles", nTicks, 32'd16);
        checkOutput("bus_to_err", 32'(err_code), 32'h3);
        checkOutput("bus_to_ctrl", 32'(ctrlVec), 32'h0);

        doReset();
        applyStimulus("addi2", 6'b001000, 6'b0, 1'b0, 0, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        opcode = 6'b101011;
        dataStall = 1000;
        updReady();
        #1;
        nTicks = 0;
        while (mem_we !== 1'b1 && nTicks < 20) begin
            tick();
            nTicks++;
        end
        checkOutput("sw_reached_memwr", 32'(mem_we), 32'h1);
        checkOutput("sw_memwr_iord", 32'(iord), 32'h1);
        tick();
        sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst_ctrl", 32'(ctrlVec), 32'h0);
        checkOutput("midrst_cnt", retired_cnt, 32'h0);
        checkOutput("midrst_err", 32'(err_code), 32'h0);
        checkOutput("midrst_halted", 32'(halted), 32'h0);
        doReset();
        applyStimulus("addi3", 6'b001000, 6'b0, 1'b0, 0, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, nTicks);
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
